// File: rtl/spi_pkg.sv
// Shared definitions for the slot-1 SPI master: FSM states, register
// offsets and CTRL/STATUS bit positions.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HA,
    HB
  } spi_state_e;

  localparam logic [4:0] SPI_RX   = 5'd0;
  localparam logic [4:0] SPI_CTRL = 5'd1;
  localparam logic [4:0] SPI_SS   = 5'd2;
  localparam logic [4:0] SPI_TX   = 5'd3;

  localparam int CTRL_CPOL_BIT    = 16;
  localparam int CTRL_CPHA_BIT    = 17;
  localparam int STATUS_READY_BIT = 8;

endpackage

// File: rtl/spi_core.sv
// Single-byte SPI master engine: half-period divider, MSB-first shift
// registers and the IDLE/DELAY/HA/HB sequencer with registered sclk/mosi.
module spi_core
  import spi_pkg::*;
#(
  parameter int DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        din,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic [7:0]        dout,
  output logic              ready,
  output logic              done_tick,
  output logic              sclk,
  output logic              mosi
);

  spi_state_e        state_q;
  logic [DVSR_W-1:0] cnt_q;
  logic [DVSR_W-1:0] dvsr_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [2:0]        bit_q;
  logic [7:0]        tx_q;
  logic [7:0]        rx_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              half_end;

  assign half_end = (cnt_q == dvsr_q);

  // NOTE: all state here is sequential, so every assignment uses <= to let
  // each register see the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= half_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          sclk_q <= cpol;
          if (start) begin
            // Timing parameters are frozen for the whole byte.
            dvsr_q  <= dvsr;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            tx_q    <= din;
            mosi_q  <= din[7];
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= cpha ? DELAY : HA;
          end
        end
        DELAY: begin
          if (half_end) begin
            sclk_q  <= cpol_q ^ cpha_q;
            state_q <= HA;
          end
        end
        HA: begin
          if (half_end) begin
            rx_q    <= {rx_q[6:0], miso};
            sclk_q  <= cpol_q ^ ~cpha_q;
            state_q <= HB;
          end
        end
        HB: begin
          if (half_end) begin
            if (bit_q == 3'd7) begin
              sclk_q  <= cpol_q;
              state_q <= IDLE;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= tx_q << 1;
              mosi_q  <= tx_q[6];
              sclk_q  <= cpol_q ^ cpha_q;
              state_q <= HA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == HB) && half_end && (bit_q == 3'd7);
  assign dout      = rx_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

endmodule

// File: rtl/spi_top.sv
// I/O slot wrapper for the SPI master: register decode, CTRL/SS/RX
// registers and the combinational read mux.
module spi_top
  import spi_pkg::*;
#(
  parameter int DVSR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        ss_n
);

  logic [DVSR_W-1:0] dvsr_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              ss_n_q;
  logic [7:0]        rx_byte_q;
  logic              wr_en;
  logic              start;
  logic              ready;
  logic              done_tick;
  logic [7:0]        core_dout;
  logic              unused_bits;

  assign wr_en = cs & write;
  // Full 5-bit compare so aliases such as addr 9 never hit a register.
  assign start = wr_en && (addr == SPI_TX);

  // Reads are side-effect free and the upper write-data bits carry nothing.
  assign unused_bits = ^{read, wr_data[31:CTRL_CPHA_BIT+1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      rx_byte_q <= '0;
    end else begin
      if (wr_en && (addr == SPI_CTRL)) begin
        dvsr_q <= wr_data[DVSR_W-1:0];
        cpol_q <= wr_data[CTRL_CPOL_BIT];
        cpha_q <= wr_data[CTRL_CPHA_BIT];
      end
      if (wr_en && (addr == SPI_SS)) begin
        ss_n_q <= wr_data[0];
      end
      if (done_tick) begin
        rx_byte_q <= core_dout;
      end
    end
  end

  // NOTE: default first so no path through this block leaves rd_data unassigned.
  always_comb begin
    rd_data = '0;
    if (addr == SPI_RX) begin
      rd_data[7:0]              = rx_byte_q;
      rd_data[STATUS_READY_BIT] = ready;
    end
  end

  spi_core #(
    .DVSR_W(DVSR_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (wr_data[7:0]),
    .dvsr     (dvsr_q),
    .cpol     (cpol_q),
    .cpha     (cpha_q),
    .miso     (miso),
    .dout     (core_dout),
    .ready    (ready),
    .done_tick(done_tick),
    .sclk     (sclk),
    .mosi     (mosi)
  );

  assign ss_n = ss_n_q;

endmodule
